// File: rtl/zigzag_reorder_buffer.sv
// zigzag_reorder_buffer: buffers one 4x4 block of coefficients written in raster
// order and streams it back out in reverse zigzag scan order (high frequency first).
// Optional feature macro: ZIGZAG_PINGPONG_EN (two banks, overlapped fill/drain).
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; valid never depends on ready, and out_coef/out_idx/out_last are held
// stable while out_valid && !out_ready.
module zigzag_reorder_buffer #(
  parameter int COEF_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_coef,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [COEF_W-1:0] out_coef,
  output logic [3:0]        out_idx,
  output logic              out_last,
  output logic              frame_err
);

  // Scan position -> raster index for the reverse zigzag order.
  function automatic logic [3:0] scan_raster(input logic [3:0] pos);
    logic [3:0] r;
    case (pos)
      4'd0:    r = 4'd15;
      4'd1:    r = 4'd14;
      4'd2:    r = 4'd11;
      4'd3:    r = 4'd7;
      4'd4:    r = 4'd10;
      4'd5:    r = 4'd13;
      4'd6:    r = 4'd12;
      4'd7:    r = 4'd9;
      4'd8:    r = 4'd6;
      4'd9:    r = 4'd3;
      4'd10:   r = 4'd2;
      4'd11:   r = 4'd5;
      4'd12:   r = 4'd8;
      4'd13:   r = 4'd4;
      4'd14:   r = 4'd1;
      default: r = 4'd0;
    endcase
    return r;
  endfunction

  logic [3:0] wr_cnt;
  logic [3:0] rd_cnt;
  logic       wr_fire;
  logic       rd_fire;

  assign wr_fire  = in_valid && in_ready;
  assign rd_fire  = out_valid && out_ready;
  assign out_idx  = rd_cnt;
  assign out_last = (rd_cnt == 4'd15);

  // Sticky framing flag: in_last must coincide with the 16th accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
    end else if (wr_fire && (in_last != (wr_cnt == 4'd15))) begin
      frame_err <= 1'b1;
    end
  end

`ifdef ZIGZAG_PINGPONG_EN

  logic [COEF_W-1:0] mem [32];
  logic [1:0]        full;
  logic [1:0]        full_next;
  logic              wr_bank;
  logic              rd_bank;
  logic              wr_done;
  logic              rd_done;

  assign in_ready  = !full[wr_bank] && !rst;
  assign out_valid = full[rd_bank] && !rst;
  assign wr_done   = wr_fire && (wr_cnt == 4'd15);
  assign rd_done   = rd_fire && (rd_cnt == 4'd15);
  assign out_coef  = mem[{rd_bank, scan_raster(rd_cnt)}];

  // Bank-full flags; a write can only complete into an empty bank and a read
  // only from a full one, so both updates never target the same bank.
  always_comb begin
    full_next = full;
    if (rd_done) full_next[rd_bank] = 1'b0;
    if (wr_done) full_next[wr_bank] = 1'b1;
  end

  // Counters, bank pointers and full flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt  <= 4'd0;
      rd_cnt  <= 4'd0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= 2'b00;
    end else begin
      full <= full_next;
      if (wr_fire) wr_cnt <= wr_cnt + 4'd1;
      if (rd_fire) rd_cnt <= rd_cnt + 4'd1;
      if (wr_done) wr_bank <= ~wr_bank;
      if (rd_done) rd_bank <= ~rd_bank;
    end
  end

  // Coefficient storage, written in raster order into the current write bank.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[{wr_bank, wr_cnt}] <= in_coef;
  end

`else

  typedef enum logic {FILL, DRAIN} state_t;

  logic [COEF_W-1:0] mem [16];
  state_t            state;
  state_t            state_next;

  assign out_coef = mem[scan_raster(rd_cnt)];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_next;
  end

  // Next state and handshake outputs; both readies are forced low in reset.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      FILL: begin
        in_ready = !rst;
        if (in_valid && !rst && (wr_cnt == 4'd15)) state_next = DRAIN;
      end
      DRAIN: begin
        out_valid = !rst;
        if (out_ready && !rst && (rd_cnt == 4'd15)) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  // Write and read counters; both wrap naturally from 15 to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt <= 4'd0;
      rd_cnt <= 4'd0;
    end else begin
      if (wr_fire) wr_cnt <= wr_cnt + 4'd1;
      if (rd_fire) rd_cnt <= rd_cnt + 4'd1;
    end
  end

  // Coefficient storage, written in raster order.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_cnt] <= in_coef;
  end

`endif

endmodule

// File: tb/tb_zigzag_reorder_buffer.sv
// tb_zigzag_reorder_buffer: directed bench for zigzag_reorder_buffer with a
// behavioural reverse-zigzag model and a per-cycle compare process.
module tb_zigzag_reorder_buffer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_coef;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_coef;
  logic [3:0]   out_idx;
  logic         out_last;
  logic         frame_err;

  zigzag_reorder_buffer #(.COEF_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_coef   (in_coef),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_coef  (out_coef),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .frame_err (frame_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int           rev_scan [16];   // scan position -> raster index
  logic [W-1:0] blk [16];        // block being collected
  int           wr_pos;
  int           out_pos;
  bit           m_err;
  logic [W-1:0] exp_q [$];       // expected output coefficients
  logic [W-1:0] got_q [$];       // coefficients actually accepted downstream
  logic [3:0]   got_idx_q [$];
  bit           prev_stall;
  logic [W-1:0] prev_coef;
  logic [3:0]   prev_idx;
  logic         prev_last;

  // Forward zigzag walks the anti-diagonals row+col=s, alternating direction;
  // the reverse scan is that order read backwards.
  task automatic build_rev_scan();
    int fwd [16];
    int k = 0;
    for (int s = 0; s <= 6; s++) begin
      int lo = (s > 3) ? s - 3 : 0;
      int hi = (s < 3) ? s : 3;
      if (s % 2 == 1) begin
        for (int r = lo; r <= hi; r++) begin fwd[k] = 4 * r + (s - r); k++; end
      end else begin
        for (int r = hi; r >= lo; r--) begin fwd[k] = 4 * r + (s - r); k++; end
      end
    end
    for (int i = 0; i < 16; i++) rev_scan[i] = fwd[15 - i];
  endtask

  // Compare process: checks outputs mid-cycle, then advances the model with
  // the handshakes that the next rising edge will perform.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_in_ready", {31'b0, in_ready}, 32'd0);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      exp_q.delete();
      wr_pos     = 0;
      out_pos    = 0;
      m_err      = 1'b0;
      prev_stall = 1'b0;
    end else begin
      int  blocks;
      bit  exp_in_ready;
      blocks = (exp_q.size() + 15) / 16;
`ifdef ZIGZAG_PINGPONG_EN
      exp_in_ready = (blocks < 2);
`else
      exp_in_ready = (blocks == 0);
`endif
      check("in_ready", {31'b0, in_ready}, {31'b0, exp_in_ready});
      check("out_valid", {31'b0, out_valid}, {31'b0, (exp_q.size() != 0)});
      check("frame_err", {31'b0, frame_err}, {31'b0, m_err});
      if (out_valid && exp_q.size() != 0) begin
        check("out_coef", {16'b0, out_coef}, {16'b0, exp_q[0]});
        check("out_idx", {28'b0, out_idx}, out_pos);
        check("out_last", {31'b0, out_last}, {31'b0, (out_pos == 15)});
        if (prev_stall) begin
          check("hold_coef", {16'b0, out_coef}, {16'b0, prev_coef});
          check("hold_idx", {28'b0, out_idx}, {28'b0, prev_idx});
          check("hold_last", {31'b0, out_last}, {31'b0, prev_last});
        end
        prev_stall = !out_ready;
        prev_coef  = out_coef;
        prev_idx   = out_idx;
        prev_last  = out_last;
        if (out_ready) begin
          got_q.push_back(out_coef);
          got_idx_q.push_back(out_idx);
          void'(exp_q.pop_front());
          out_pos = (out_pos + 1) % 16;
        end
      end else begin
        prev_stall = 1'b0;
      end
      if (in_valid && in_ready) begin
        blk[wr_pos] = in_coef;
        if (in_last != (wr_pos == 15)) m_err = 1'b1;
        if (wr_pos == 15) begin
          for (int i = 0; i < 16; i++) exp_q.push_back(blk[rev_scan[i]]);
        end
        wr_pos = (wr_pos + 1) % 16;
      end
    end
  end

  // ---------------- downstream ready driver ----------------
  int ready_mode = 0;  // 0: always ready, 1: pattern 1,0,0, 2: manual
  int ready_ph   = 0;

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = (ready_ph == 0);
          ready_ph  = (ready_ph + 1) % 3;
        end
        default: ;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_one(input logic [W-1:0] v, input logic last);
    int  n = 0;
    bit  acc;
    in_valid = 1'b1;
    in_coef  = v;
    in_last  = last;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 200) begin
        check("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_block(input logic [W-1:0] vals [16], input int last_pos, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_one(vals[i], (i == last_pos));
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) check("drain_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  logic [W-1:0] basic_exp [16] = '{16'd16, 16'd15, 16'd12, 16'd8, 16'd11, 16'd14, 16'd13, 16'd10,
                                   16'd7, 16'd4, 16'd3, 16'd6, 16'd9, 16'd5, 16'd2, 16'd1};
  logic [W-1:0] vals [16];

  initial begin
    build_rev_scan();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_coef  = '0;
    in_last  = 1'b0;

    // Reset state.
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    check("reset_in_ready_low", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", {31'b0, in_ready}, 32'd1);
    check("post_reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("post_reset_frame_err", {31'b0, frame_err}, 32'd0);
    check("post_reset_out_idx", {28'b0, out_idx}, 32'd0);
    check("post_reset_out_last", {31'b0, out_last}, 32'd0);
    @(posedge clk); #1;

    // Basic order, with first-output latency.
    for (int i = 0; i < 16; i++) vals[i] = W'(i + 1);
    got_q.delete();
    got_idx_q.delete();
    send_block(vals, 15, 1'b0);
    @(negedge clk);
    check("latency_out_valid", {31'b0, out_valid}, 32'd1);
    check("latency_out_idx", {28'b0, out_idx}, 32'd0);
    wait_drain();
    check("basic_count", got_q.size(), 32'd16);
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      check($sformatf("basic_coef_%0d", i), {16'b0, got_q[i]}, {16'b0, basic_exp[i]});
      check($sformatf("basic_idx_%0d", i), {28'b0, got_idx_q[i]}, i);
    end

    // Backpressure with gapped input.
    ready_mode = 1;
    got_q.delete();
    got_idx_q.delete();
    send_block(vals, 15, 1'b1);
    wait_drain();
    check("bp_count", got_q.size(), 32'd16);
    for (int i = 0; i < 16 && i < got_q.size(); i++)
      check($sformatf("bp_coef_%0d", i), {16'b0, got_q[i]}, {16'b0, basic_exp[i]});
    ready_mode = 0;

    // Signed extremes: even raster positions -32768, odd 32767.
    for (int i = 0; i < 16; i++) vals[i] = (i % 2 == 0) ? 16'h8000 : 16'h7fff;
    got_q.delete();
    got_idx_q.delete();
    send_block(vals, 15, 1'b0);
    wait_drain();
    check("signed_count", got_q.size(), 32'd16);
    if (got_q.size() >= 5) begin
      check("signed_first", {16'b0, got_q[0]}, 32'h7fff);
      check("signed_second", {16'b0, got_q[1]}, 32'h8000);
      check("signed_fifth", {16'b0, got_q[4]}, 32'h8000);
    end

    // Reset mid-drain after 5 outputs.
    for (int i = 0; i < 16; i++) vals[i] = W'(16'h0100 + i);
    ready_mode = 2;
    out_ready  = 1'b0;
    send_block(vals, 15, 1'b0);
    out_ready = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    rst       = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    ready_mode = 0;
    for (int i = 0; i < 16; i++) vals[i] = W'(16'h0200 + i);
    got_q.delete();
    got_idx_q.delete();
    send_block(vals, 15, 1'b0);
    wait_drain();
    check("fresh_count", got_q.size(), 32'd16);
    if (got_idx_q.size() > 0) begin
      check("fresh_first_idx", {28'b0, got_idx_q[0]}, 32'd0);
      check("fresh_first_coef", {16'b0, got_q[0]}, 32'h020f);
    end

    // Framing error: in_last on the 10th sample.
    for (int i = 0; i < 16; i++) vals[i] = W'(16'hf000 + i);
    got_q.delete();
    got_idx_q.delete();
    send_block(vals, 9, 1'b0);
    @(negedge clk);
    check("frame_err_set", {31'b0, frame_err}, 32'd1);
    wait_drain();
    check("frame_count", got_q.size(), 32'd16);
    check("frame_err_sticky", {31'b0, frame_err}, 32'd1);
    do_reset();
    @(negedge clk);
    check("frame_err_cleared", {31'b0, frame_err}, 32'd0);
    @(posedge clk); #1;

`ifdef ZIGZAG_PINGPONG_EN
    // Three blocks back-to-back; the model checks in_ready and out_valid each cycle.
    got_q.delete();
    got_idx_q.delete();
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 16; i++) vals[i] = W'(16 * b + i);
      send_block(vals, 15, 1'b0);
    end
    wait_drain();
    check("pp_count", got_q.size(), 32'd48);
    if (got_q.size() == 48) begin
      check("pp_blk2_first", {16'b0, got_q[16]}, 32'd31);
      check("pp_blk3_last", {16'b0, got_q[47]}, 32'd32);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
